// File: rtl/mips_multicycle_core_if.sv
// Shared memory bus between the multicycle core and its single external memory.
// One request/ready handshake carries fetches, loads and stores.
interface mips_multicycle_core_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: fetch/decode/exec/mem/writeback sequenced over one
// request/ready memory bus, with illegal-instruction and misalignment trapping.
//
// state    | meaning
// S_FETCH  | request instruction at PC; on accept latch IR, PC += 4
// S_DECODE | read rs/rt into A/B, precompute branch target into ALUOut
// S_EXEC   | ALU op, address calc, branch/jump resolution, trap detection
// S_MEM    | load or store at ALUOut; store retires on accept
// S_WB     | write ALUOut or MDR to the destination register, retire
// S_TRAP   | halted until reset; bus idle
module mips_multicycle_core #(
  parameter int          ADDR_WIDTH    = 12,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          INSTRET_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  mips_multicycle_core_if.master   bus,
  output logic [31:0]              pc,
  output logic                     trap,
  output logic [INSTRET_WIDTH-1:0] instret,
  input  logic [4:0]               dbg_raddr,
  output logic [31:0]              dbg_rdata
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [INSTRET_WIDTH-1:0] INSTRET_ONE = INSTRET_WIDTH'(1);

  state_t state, state_next;

  logic [31:0] ir, a_reg, b_reg, alu_out, mdr;
  logic [31:0] regs [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, addr_calc, alu_r, wb_data;
  logic [4:0]  wb_dest;
  logic        funct_ok, is_store, branch_taken;

  logic                  req_c, we_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [31:0]           wdata_c;

  assign opcode    = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign funct     = ir[5:0];
  assign imm_sext  = {{16{ir[15]}}, ir[15:0]};
  assign addr_calc = a_reg + imm_sext;
  assign is_store  = (opcode == OP_SW);

  assign branch_taken = (opcode == OP_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);

  always_comb begin
    alu_r    = '0;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_r = a_reg + b_reg;
      FN_SUB:  alu_r = a_reg - b_reg;
      FN_AND:  alu_r = a_reg & b_reg;
      FN_OR:   alu_r = a_reg | b_reg;
      FN_SLT:  alu_r = {31'd0, ($signed(a_reg) < $signed(b_reg))};
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    wb_dest = rt;
    wb_data = alu_out;
    case (opcode)
      OP_RTYPE: wb_dest = rd;
      OP_LW:    wb_data = mdr;
      default:  ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    we_c       = 1'b0;
    addr_c     = '0;
    wdata_c    = '0;
    case (state)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = {pc[ADDR_WIDTH-1:2], 2'b00};
        if (bus.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_RTYPE:            state_next = funct_ok ? S_WB : S_TRAP;
          OP_ADDI:             state_next = S_WB;
          OP_LW, OP_SW:        state_next = (addr_calc[1:0] != 2'b00) ? S_TRAP : S_MEM;
          OP_BEQ, OP_BNE, OP_J: state_next = S_FETCH;
          default:             state_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        req_c   = 1'b1;
        we_c    = is_store;
        addr_c  = {alu_out[ADDR_WIDTH-1:2], 2'b00};
        wdata_c = is_store ? b_reg : 32'd0;
        if (bus.mem_ready) state_next = is_store ? S_FETCH : S_WB;
      end
      S_WB:    state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
  end

  // Reset gates the request so an in-flight access is dropped without waiting for a clock.
  assign bus.mem_req   = req_c & ~reset;
  assign bus.mem_we    = we_c;
  assign bus.mem_addr  = addr_c;
  assign bus.mem_wdata = wdata_c;

  assign trap      = (state == S_TRAP);
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : regs[dbg_raddr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      instret <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            ir <= bus.mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a_reg   <= regs[rs];
          b_reg   <= regs[rt];
          alu_out <= pc + {imm_sext[29:0], 2'b00};
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE:             alu_out <= alu_r;
            OP_ADDI, OP_LW, OP_SW: alu_out <= addr_calc;
            OP_BEQ, OP_BNE: begin
              if (branch_taken) pc <= alu_out;
              instret <= instret + INSTRET_ONE;
            end
            OP_J: begin
              pc      <= {pc[31:28], ir[25:0], 2'b00};
              instret <= instret + INSTRET_ONE;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (is_store) instret <= instret + INSTRET_ONE;
            else          mdr     <= bus.mem_rdata;
          end
        end
        S_WB: begin
          if (wb_dest != 5'd0) regs[wb_dest] <= wb_data;
          instret <= instret + INSTRET_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench: wait-state memory model plus an instruction-level ISA model
// that predicts registers, memory, PC, retire count and cycles per instruction.
module tb_mips_multicycle_core;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic        trap;
  logic [31:0] instret;
  logic [4:0]  dbg_raddr = 5'd0;
  logic [31:0] dbg_rdata;

  mips_multicycle_core_if #(.ADDR_WIDTH(12)) bus ();

  mips_multicycle_core #(
    .ADDR_WIDTH(12),
    .RESET_PC(RESET_PC),
    .INSTRET_WIDTH(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .pc(pc),
    .trap(trap),
    .instret(instret),
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata)
  );

  always #5 clock = ~clock;

  // memory model: img is the program image copied in while reset is held
  logic [31:0] mem [1024];
  logic [31:0] img [1024];
  logic [31:0] model_mem [1024];
  logic [31:0] regs_m [32];
  logic [31:0] pc_m;
  logic [31:0] instret_m;

  int          wait_states = 0;
  int          wait_cnt = 0;
  int          n_writes = 0;
  int          stab_err = 0;
  int          addr8_cycles = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  bit          load_img = 1'b0;
  bit          pending = 1'b0;
  logic [11:0] h_addr = '0;
  logic        h_we = 1'b0;
  logic [31:0] h_wdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clock) begin
    if (reset) begin
      wait_cnt <= 0;
      pending  <= 1'b0;
      if (load_img) for (int i = 0; i < 1024; i++) mem[i] <= img[i];
    end else if (bus.mem_req) begin
      if (pending && (bus.mem_addr != h_addr || bus.mem_we != h_we ||
                      (h_we && bus.mem_wdata != h_wdata)))
        stab_err <= stab_err + 1;
      if (bus.mem_addr == 12'h008) addr8_cycles <= addr8_cycles + 1;
      if (bus.mem_ready) begin
        if (bus.mem_we) begin
          mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
          n_writes   <= n_writes + 1;
          last_waddr <= {20'd0, bus.mem_addr};
          last_wdata <= bus.mem_wdata;
        end
        pending  <= 1'b0;
        wait_cnt <= 0;
      end else begin
        pending  <= 1'b1;
        h_addr   <= bus.mem_addr;
        h_we     <= bus.mem_we;
        h_wdata  <= bus.mem_wdata;
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  always @(negedge clock) bus.mem_ready <= (wait_cnt >= wait_states);

  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 32'd0;
  endtask

  task automatic wr_m(input int d, input logic [31:0] v);
    if (d != 0) regs_m[d] = v;
  endtask

  // ISA-level model of one instruction at pc_m
  task automatic model_step(input int w, output int cyc, output bit trp);
    logic [31:0] ins, rsv, rtv, sx, res, addr, npc;
    int op, fn, rs, rt, rd;
    ins = model_mem[pc_m[11:2]];
    op  = int'(ins[31:26]);
    rs  = int'(ins[25:21]);
    rt  = int'(ins[20:16]);
    rd  = int'(ins[15:11]);
    fn  = int'(ins[5:0]);
    rsv = regs_m[rs];
    rtv = regs_m[rt];
    sx  = {{16{ins[15]}}, ins[15:0]};
    res = 32'd0;
    npc = pc_m + 32'd4;
    trp = 1'b0;
    cyc = 3 + w;
    case (op)
      0: begin
        case (fn)
          32: res = rsv + rtv;
          34: res = rsv - rtv;
          36: res = rsv & rtv;
          37: res = rsv | rtv;
          42: res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
          default: trp = 1'b1;
        endcase
        if (!trp) begin
          wr_m(rd, res);
          cyc = 4 + w;
        end
      end
      8: begin
        wr_m(rt, rsv + sx);
        cyc = 4 + w;
      end
      35: begin
        addr = rsv + sx;
        if (addr % 4 != 0) trp = 1'b1;
        else begin
          wr_m(rt, model_mem[addr[11:2]]);
          cyc = 5 + 2 * w;
        end
      end
      43: begin
        addr = rsv + sx;
        if (addr % 4 != 0) trp = 1'b1;
        else begin
          model_mem[addr[11:2]] = rtv;
          cyc = 4 + 2 * w;
        end
      end
      4: if (rsv == rtv) npc = npc + sx * 4;
      5: if (rsv != rtv) npc = npc + sx * 4;
      2: npc = {npc[31:28], ins[25:0], 2'b00};
      default: trp = 1'b1;
    endcase
    if (!trp) begin
      pc_m      = npc;
      instret_m = instret_m + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    load_img = 1'b1;
    #1;
    chk("rst.req_async", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst.pc", pc, RESET_PC);
    chk("rst.trap", {31'd0, trap}, 32'd0);
    chk("rst.instret", instret, 32'd0);
    for (int r = 0; r < 32; r++) begin
      dbg_raddr = 5'(r);
      #1;
      chk($sformatf("rst.reg%0d", r), dbg_rdata, 32'd0);
    end
    @(negedge clock);
    reset    = 1'b0;
    load_img = 1'b0;
    #1;
    chk("rst.fetch_req", {31'd0, bus.mem_req}, 32'd1);
    chk("rst.fetch_addr", {20'd0, bus.mem_addr}, {20'd0, RESET_PC[11:0]});
    chk("rst.fetch_we", {31'd0, bus.mem_we}, 32'd0);
  endtask

  task automatic run_prog(input string name, input int w);
    int cyc, exp_cyc, s0;
    bit exp_trap;
    logic [31:0] prev;
    wait_states = w;
    for (int i = 0; i < 1024; i++) model_mem[i] = img[i];
    for (int r = 0; r < 32; r++) regs_m[r] = 32'd0;
    pc_m      = RESET_PC;
    instret_m = 32'd0;
    exp_trap  = 1'b0;
    do_reset();
    s0 = stab_err;
    for (int step = 0; step < 200; step++) begin
      model_step(w, exp_cyc, exp_trap);
      prev = instret;
      cyc  = 0;
      while (cyc < 100) begin
        @(posedge clock);
        #1;
        cyc++;
        if (trap === 1'b1 || instret !== prev) break;
      end
      chk($sformatf("%s.cpi@%0h", name, pc_m), 32'(cyc), 32'(exp_cyc));
      if (exp_trap) begin
        chk({name, ".trap"}, {31'd0, trap}, 32'd1);
        chk({name, ".trap_req"}, {31'd0, bus.mem_req}, 32'd0);
        chk({name, ".trap_pc"}, pc, pc_m + 32'd4);
        chk({name, ".trap_instret"}, instret, instret_m);
        repeat (4) @(posedge clock);
        #1;
        chk({name, ".frozen_pc"}, pc, pc_m + 32'd4);
        chk({name, ".frozen_instret"}, instret, instret_m);
        chk({name, ".frozen_req"}, {31'd0, bus.mem_req}, 32'd0);
        break;
      end
      chk($sformatf("%s.pc@%0d", name, step), pc, pc_m);
      chk($sformatf("%s.instret@%0d", name, step), instret, instret_m);
      chk($sformatf("%s.notrap@%0d", name, step), {31'd0, trap}, 32'd0);
    end
    chk({name, ".ended_in_trap"}, {31'd0, trap}, 32'd1);
    for (int r = 0; r < 32; r++) begin
      dbg_raddr = 5'(r);
      #1;
      chk($sformatf("%s.reg%0d", name, r), dbg_rdata, regs_m[r]);
    end
    for (int i = 128; i < 144; i++)
      chk($sformatf("%s.mem%0d", name, i), mem[i], model_mem[i]);
    chk({name, ".bus_stable"}, 32'(stab_err - s0), 32'd0);
  endtask

  task automatic gen_random();
    int n, kind;
    logic [4:0] ra, rb, rc;
    logic [5:0] fn;
    clear_img();
    for (int i = 1; i < 8; i++) img[i-1] = enc_i(6'd8, 5'(i), 5'd0, 16'($urandom));
    for (int i = 128; i < 144; i++) img[i] = $urandom;
    n = 7;
    repeat (20) begin
      kind = $urandom_range(0, 9);
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      rc = 5'($urandom_range(0, 7));
      fn = 6'd32;
      case (kind)
        1: fn = 6'd34;
        2: fn = 6'd36;
        3: fn = 6'd37;
        4: fn = 6'd42;
        default: ;
      endcase
      case (kind)
        0, 1, 2, 3, 4: img[n] = enc_r(fn, ra, rb, rc);
        5: img[n] = enc_i(6'd8, ra, rb, 16'($urandom));
        6: img[n] = enc_i(6'd35, ra, 5'd0, 16'(512 + 4 * $urandom_range(0, 15)));
        7: img[n] = enc_i(6'd43, ra, 5'd0, 16'(512 + 4 * $urandom_range(0, 15)));
        8: img[n] = enc_i(6'd4, ra, rb, 16'($urandom_range(0, 3)));
        default: img[n] = enc_i(6'd5, ra, rb, 16'($urandom_range(0, 3)));
      endcase
      n++;
    end
    case ($urandom_range(0, 3))
      0: img[n] = enc_r(6'd33, 5'd1, 5'd2, 5'd3);
      1: img[n] = 32'hFC00_0000;
      2: img[n] = enc_i(6'd35, 5'd1, 5'd0, 16'h0202);
      default: img[n] = enc_i(6'd43, 5'd1, 5'd0, 16'h0201);
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int w0, a0, cyc;
    bit found;

    // ADD r3 = r1 + r2 with zero-wait memory
    clear_img();
    img[0] = enc_i(6'd8, 5'd1, 5'd0, 16'd5);
    img[1] = enc_i(6'd8, 5'd2, 5'd0, 16'd7);
    img[2] = enc_r(6'd32, 5'd3, 5'd1, 5'd2);
    run_prog("add", 0);
    dbg_raddr = 5'd3;
    #1;
    chk("add.r3", dbg_rdata, 32'd12);
    chk("add.instret", instret, 32'd3);

    // LW with two wait states on every access
    clear_img();
    img[0] = enc_i(6'd35, 5'd4, 5'd0, 16'd8);
    img[2] = 32'hDEAD_BEEF;
    a0 = addr8_cycles;
    run_prog("lw", 2);
    dbg_raddr = 5'd4;
    #1;
    chk("lw.r4", dbg_rdata, 32'hDEAD_BEEF);
    chk("lw.addr8_cycles", 32'(addr8_cycles - a0), 32'd3);

    // SW r1 -> 12
    clear_img();
    img[0] = enc_i(6'd8, 5'd1, 5'd0, 16'd5);
    img[1] = enc_i(6'd43, 5'd1, 5'd0, 16'd12);
    w0 = n_writes;
    run_prog("sw", 0);
    chk("sw.nwrites", 32'(n_writes - w0), 32'd1);
    chk("sw.addr", last_waddr, 32'd12);
    chk("sw.data", last_wdata, 32'd5);
    chk("sw.mem", mem[3], 32'd5);

    // BEQ taken at 0x10, BNE not taken, J 0x40
    clear_img();
    img[0]  = enc_i(6'd8, 5'd1, 5'd0, 16'd3);
    img[1]  = enc_i(6'd8, 5'd2, 5'd0, 16'd4);
    img[2]  = enc_i(6'd8, 5'd0, 5'd0, 16'd0);
    img[3]  = enc_i(6'd8, 5'd0, 5'd0, 16'd0);
    img[4]  = enc_i(6'd4, 5'd1, 5'd1, 16'd3);
    img[5]  = enc_i(6'd8, 5'd6, 5'd0, 16'd1);
    img[6]  = enc_i(6'd8, 5'd6, 5'd0, 16'd1);
    img[7]  = enc_i(6'd8, 5'd6, 5'd0, 16'd1);
    img[8]  = enc_i(6'd5, 5'd1, 5'd1, 16'd5);
    img[9]  = {6'd2, 26'h40};
    img[64] = enc_i(6'd8, 5'd5, 5'd0, 16'd77);
    img[65] = 32'hFC00_0000;
    run_prog("branch", 1);
    dbg_raddr = 5'd6;
    #1;
    chk("branch.skipped_r6", dbg_rdata, 32'd0);
    dbg_raddr = 5'd5;
    #1;
    chk("branch.jump_r5", dbg_rdata, 32'd77);
    chk("branch.pc", pc, 32'h108);

    // ADDI to r0 then illegal opcode
    clear_img();
    img[0] = enc_i(6'd8, 5'd0, 5'd0, 16'd1);
    img[1] = 32'hFC00_0000;
    run_prog("trap", 0);
    dbg_raddr = 5'd0;
    #1;
    chk("trap.r0", dbg_rdata, 32'd0);
    chk("trap.instret", instret, 32'd1);
    chk("trap.flag", {31'd0, trap}, 32'd1);

    // random programs, random wait states
    for (int p = 0; p < 6; p++) begin
      gen_random();
      run_prog($sformatf("rnd%0d", p), $urandom_range(0, 2));
    end

    // reset while a store is waiting for mem_ready
    clear_img();
    img[0] = enc_i(6'd8, 5'd1, 5'd0, 16'd5);
    img[1] = enc_i(6'd43, 5'd1, 5'd0, 16'd12);
    wait_states = 4;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(posedge clock);
      #1;
      if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) found = 1'b1;
    end
    chk("rstsw.found_store", {31'd0, found}, 32'd1);
    chk("rstsw.pre_instret", instret, 32'd1);
    chk("rstsw.pre_addr", {20'd0, bus.mem_addr}, 32'd12);
    chk("rstsw.pre_wdata", bus.mem_wdata, 32'd5);
    w0 = n_writes;
    #2;
    reset    = 1'b1;
    load_img = 1'b1;
    #1;
    chk("rstsw.req", {31'd0, bus.mem_req}, 32'd0);
    chk("rstsw.trap", {31'd0, trap}, 32'd0);
    chk("rstsw.pc", pc, RESET_PC);
    chk("rstsw.instret", instret, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    load_img = 1'b0;
    #1;
    chk("rstsw.restart_req", {31'd0, bus.mem_req}, 32'd1);
    chk("rstsw.restart_addr", {20'd0, bus.mem_addr}, {20'd0, RESET_PC[11:0]});
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
      if (instret !== 32'd0) break;
    end
    chk("rstsw.refetch_cpi", 32'(cyc), 32'd8);
    chk("rstsw.no_write", 32'(n_writes - w0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multicycle MIPS-subset CPU core. Fetch, decode, execute, memory and writeback run as a state machine over a single shared external memory bus with a request/ready handshake, so wait-state memories are supported. Compared with the earlier single-memory core, it adds:

- a wider instruction set;
- a configurable reset vector and address width;
- illegal-instruction and misalignment trapping;
- a retired-instruction counter;
- a debug register-read port for verification.

## Interface
Parameters:
- ADDR_WIDTH, 12: byte-address width driven on mem_addr (addresses 2^ADDR_WIDTH bytes).
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- INSTRET_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mem_req  out  1  memory access request; held until accepted.
- mem_we  out  1  1 = write (SW), 0 = read (fetch or LW); valid while mem_req=1.
- mem_addr  out  ADDR_WIDTH  byte address, always word-aligned (bits [1:0]=0).
- mem_wdata  out  32  store data; valid while mem_req=1 and mem_we=1.
- mem_rdata  in  32  read data; sampled on the edge where mem_ready=1.
- mem_ready  in  1  access completes on the rising edge where mem_req=1 and mem_ready=1; ignored when mem_req=0.
- pc  out  32  current PC.
- trap  out  1  core halted on an illegal opcode/funct or misaligned LW/SW.
- instret  out  INSTRET_WIDTH  count of retired instructions; wraps modulo 2^INSTRET_WIDTH.
- dbg_raddr  in  5  debug register index.
- dbg_rdata  out  32  combinational read of Regs[dbg_raddr] (index 0 reads 0).

## Operation
States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC[ADDR_WIDTH-1:0].
  - On the accepting edge: IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - Stays in FETCH while mem_ready=0.
- DECODE: A<=Regs[rs], B<=Regs[rt], ALUOut<=PC+(signext(imm)<<2); go to EXEC.
- EXEC, by opcode:
  - R-type (op 0):
    - Funct 32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT (signed). Result goes to ALUOut; go to WB.
    - Any other funct goes to TRAP.
  - ADDI (8): ALUOut<=A+signext(imm); go to WB.
  - LW (35), SW (43):
    - ALUOut<=A+signext(imm); go to MEM.
    - If that address has bits [1:0]≠0, go to TRAP instead.
  - BEQ (4), BNE (5): if the condition holds, PC<=ALUOut; retire; go to FETCH.
  - J (2): PC<={PC[31:28], IR[25:0], 2'b00}; retire; go to FETCH.
  - Any other opcode goes to TRAP.
- MEM:
  - mem_req=1, mem_addr=ALUOut[ADDR_WIDTH-1:0].
  - LW: mem_we=0; on accept MDR<=mem_rdata, go to WB.
  - SW: mem_we=1, mem_wdata=B; on accept retire, go to FETCH.
- WB: write the result to Regs[dest], retire, go to FETCH.
  - R-type: dest = rd, result = ALUOut.
  - ADDI: dest = rt, result = ALUOut.
  - LW: dest = rt, result = MDR.
  - Writes with dest = 0 are discarded; register 0 always reads 0.
- TRAP: trap=1, mem_req=0; no further state changes until reset. A trapping instruction does not retire.
- Retire means instret increments by 1 on that edge.
- Arithmetic is 32-bit with wrap-around; overflow is ignored (no exception).
- Address bits of ALUOut above ADDR_WIDTH are ignored.

## Timing
- Reset values:
  - PC = RESET_PC, state = FETCH, all 32 registers = 0.
  - IR, A, B, ALUOut, MDR = 0; instret = 0; trap = 0.
  - mem_req is asserted combinationally from FETCH right after reset release.
- mem_req, mem_we, mem_addr and mem_wdata are decoded from registered state only and stay stable until accepted.
- Cycles per instruction with zero-wait memory (mem_ready tied high):
  - R-type and ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ, BNE and J: 3.
- Each wait cycle (mem_ready=0 while mem_req=1) adds 1 cycle.
- A write performed in WB is visible to the next instruction's DECODE, so there are no hazards.
- Reset asserted mid-access drops mem_req asynchronously. The pending store is abandoned, and the memory side treats the access as cancelled.
- If mem_ready is high in a cycle where mem_req=0, the core does nothing.

## Test plan
- Zero-wait memory; Regs 1=5, 2=7; ADD r3,r1,r2 at address 0. Required: dbg_rdata(3)=12 and instret=1 after 4 cycles; PC=4.
- LW r4,8(r0) with mem[8]=32'hDEADBEEF and 2 wait states on each access. Required: r4=DEADBEEF after 9 cycles; mem_addr holds 8 during the data wait cycles.
- SW r1,12(r0) with r1=5. Required: exactly one accepted write with mem_we=1, mem_addr=12, mem_wdata=5; then FETCH at PC=4.
- BEQ r1,r1,+3 at address 0x10. Required: PC=0x20 after 3 cycles. BNE on equal operands falls through to 0x14. J 0x40 sets PC=0x100.
- ADDI r0,r0,1, then opcode 6'h3F. Required: r0 still reads 0; trap=1 from the opcode's EXEC edge onward; mem_req=0; instret=1; state stays frozen.
- Reset asserted while SW waits with mem_ready=0. Required: mem_req=0 and trap=0 immediately; PC=RESET_PC; instret=0; the fetch restarts after release.
